// File: rtl/mux256_feeder.sv
// mux256_feeder: collects a byte stream into a wide vector for the 256:1
// bit-select mux, then walks the mux select over a programmed index range.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for the first byte of a new vector
// ST_LOAD   | collecting the remaining bytes, byte_cnt = next byte slot
// ST_LOADED | full vector held on mux_in, waiting for start
// ST_SWEEP  | issuing one select index per clock, cur = index on mux_sel
// ST_DONE   | one-cycle completion pulse, then back to ST_IDLE
module mux256_feeder #(
  parameter int DATA_WIDTH = 256,
  parameter int SEL_WIDTH  = 8,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BYTE_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  sel_first,
  input  logic [SEL_WIDTH-1:0]  sel_last,
  output logic [DATA_WIDTH-1:0] mux_in,
  output logic [SEL_WIDTH-1:0]  mux_sel,
  output logic                  sel_valid,
  output logic                  loaded,
  output logic                  done
);

  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOADED,
    ST_SWEEP,
    ST_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     byte_cnt, byte_cnt_nxt;
  logic [SEL_WIDTH-1:0] cur, cur_nxt;
  logic [SEL_WIDTH-1:0] last_r, last_nxt;
  logic                 accept;
  logic                 wr_en;

  // s_ready is the registered handshake output, so acceptance needs no
  // combinational path from s_valid back to s_ready.
  assign accept = s_valid && s_ready;

  // State, byte counter and sweep index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      cur      <= '0;
      last_r   <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      cur      <= cur_nxt;
      last_r   <= last_nxt;
    end
  end

  // Next-state, counter and sweep-index logic.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    cur_nxt      = cur;
    last_nxt     = last_r;
    wr_en        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          wr_en        = 1'b1;
          byte_cnt_nxt = CNT_W'(1);
          state_nxt    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en        = 1'b1;
          // Wraps to 0 on the final byte so the next vector starts at slot 0.
          byte_cnt_nxt = byte_cnt + CNT_W'(1);
          if (byte_cnt == LAST_BYTE) begin
            state_nxt = ST_LOADED;
          end
        end
      end
      ST_LOADED: begin
        if (start) begin
          cur_nxt   = sel_first;
          last_nxt  = sel_last;
          state_nxt = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (cur == last_r) begin
          state_nxt = ST_DONE;
        end else begin
          cur_nxt = cur + SEL_WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Byte-lane write into the held vector; untouched lanes keep old data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mux_in <= '0;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_en && (byte_cnt == CNT_W'(i))) begin
          mux_in[i*BYTE_WIDTH +: BYTE_WIDTH] <= s_data;
        end
      end
    end
  end

  // Outputs registered from the next state so they line up with the state
  // they describe; mux_sel follows cur and so holds between sweeps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ready   <= 1'b0;
      loaded    <= 1'b0;
      sel_valid <= 1'b0;
      done      <= 1'b0;
      mux_sel   <= '0;
    end else begin
      s_ready   <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
      loaded    <= (state_nxt == ST_LOADED);
      sel_valid <= (state_nxt == ST_SWEEP);
      done      <= (state_nxt == ST_DONE);
      mux_sel   <= cur_nxt;
    end
  end

endmodule

// File: tb/tb_mux256_feeder.sv
// Bench for mux256_feeder: byte loads with stalls, sweeps checked against
// an index list computed from first/last, and reset during a sweep.
module tb_mux256_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic         start;
  logic [7:0]   sel_first;
  logic [7:0]   sel_last;
  logic [255:0] mux_in;
  logic [7:0]   mux_sel;
  logic         sel_valid;
  logic         loaded;
  logic         done;

  logic [255:0] exp_vec;
  int           errs   = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  mux256_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .start     (start),
    .sel_first (sel_first),
    .sel_last  (sel_last),
    .mux_in    (mux_in),
    .mux_sel   (mux_sel),
    .sel_valid (sel_valid),
    .loaded    (loaded),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: bytes 0..31 with s_valid low every 3rd cycle; mode 1: random
  // bytes and random stalls. start_last raises start with the final byte.
  task automatic load_vector(input int mode, input bit start_last);
    int k = 0;
    int cyc = 0;
    while (k < 32 && cyc < 400) begin
      chk("load_s_ready", 256'(s_ready), 256'(1));
      chk("load_loaded", 256'(loaded), 256'(0));
      chk("load_sel_valid", 256'(sel_valid), 256'(0));
      chk("load_mux_in", mux_in, exp_vec);
      if (mode == 0) begin
        s_valid = (cyc % 3) != 2;
        s_data  = 8'(k);
      end else begin
        s_valid = $urandom_range(0, 3) != 0;
        s_data  = 8'($urandom);
      end
      start = start_last && (k == 31) && s_valid;
      tick();
      if (s_valid) begin
        exp_vec[8*k +: 8] = s_data;
        k++;
      end
      cyc++;
    end
    chk("load_budget", 256'(k), 256'(32));
    start = 1'b0;
    chk("full_loaded", 256'(loaded), 256'(1));
    chk("full_s_ready", 256'(s_ready), 256'(0));
    chk("full_mux_in", mux_in, exp_vec);
    chk("full_sel_valid", 256'(sel_valid), 256'(0));
    s_valid = 1'b1;
    s_data  = 8'hAA;
    tick();
    chk("extra_byte_mux_in", mux_in, exp_vec);
    chk("extra_byte_loaded", 256'(loaded), 256'(1));
    chk("extra_byte_s_ready", 256'(s_ready), 256'(0));
    chk("early_start_sel_valid", 256'(sel_valid), 256'(0));
    s_valid = 1'b0;
  endtask

  // Expected index list is simply first, first+1, ... (mod 256) up to last.
  // rst_at >= 0 drops rst_n during that sweep cycle instead of finishing.
  task automatic sweep(input logic [7:0] f, input logic [7:0] l, input int rst_at);
    int n = ((int'(l) - int'(f)) & 255) + 1;
    start     = 1'b1;
    sel_first = f;
    sel_last  = l;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("sweep_sel_valid", 256'(sel_valid), 256'(1));
      chk("sweep_mux_sel", 256'(mux_sel), 256'((int'(f) + i) & 255));
      chk("sweep_done", 256'(done), 256'(0));
      chk("sweep_loaded", 256'(loaded), 256'(0));
      chk("sweep_s_ready", 256'(s_ready), 256'(0));
      chk("sweep_mux_in", mux_in, exp_vec);
      if (i == rst_at) begin
        s_valid = 1'b0;
        start   = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
        exp_vec = '0;
        chk("midrst_sel_valid", 256'(sel_valid), 256'(0));
        chk("midrst_mux_in", mux_in, exp_vec);
        chk("midrst_done", 256'(done), 256'(0));
        chk("midrst_mux_sel", 256'(mux_sel), 256'(0));
        chk("midrst_s_ready", 256'(s_ready), 256'(0));
        repeat (3) begin
          tick();
          chk("postrst_s_ready", 256'(s_ready), 256'(1));
          chk("postrst_done", 256'(done), 256'(0));
          chk("postrst_sel_valid", 256'(sel_valid), 256'(0));
        end
        return;
      end
      s_valid   = 1'($urandom_range(0, 1));
      s_data    = 8'($urandom);
      start     = 1'($urandom_range(0, 1));
      sel_first = 8'($urandom);
      sel_last  = 8'($urandom);
      tick();
    end
    s_valid = 1'b0;
    start   = 1'b0;
    chk("end_sel_valid", 256'(sel_valid), 256'(0));
    chk("end_done", 256'(done), 256'(1));
    chk("end_mux_sel_hold", 256'(mux_sel), 256'(l));
    chk("end_mux_in", mux_in, exp_vec);
    tick();
    chk("idle_done", 256'(done), 256'(0));
    chk("idle_sel_valid", 256'(sel_valid), 256'(0));
    chk("idle_s_ready", 256'(s_ready), 256'(1));
    chk("idle_mux_in_held", mux_in, exp_vec);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    start     = 1'b0;
    sel_first = 8'h00;
    sel_last  = 8'h00;
    exp_vec   = '0;

    repeat (3) begin
      tick();
      chk("rst_s_ready", 256'(s_ready), 256'(0));
      chk("rst_loaded", 256'(loaded), 256'(0));
      chk("rst_sel_valid", 256'(sel_valid), 256'(0));
      chk("rst_done", 256'(done), 256'(0));
      chk("rst_mux_sel", 256'(mux_sel), 256'(0));
      chk("rst_mux_in", mux_in, 256'(0));
    end
    rst_n = 1'b1;
    tick();
    chk("release_s_ready", 256'(s_ready), 256'(1));
    start     = 1'b1;
    sel_first = 8'd3;
    sel_last  = 8'd7;
    tick();
    start = 1'b0;
    repeat (3) begin
      chk("idle_start_sel_valid", 256'(sel_valid), 256'(0));
      chk("idle_start_s_ready", 256'(s_ready), 256'(1));
      chk("idle_start_loaded", 256'(loaded), 256'(0));
      tick();
    end

    load_vector(0, 1'b0);
    chk("byte0_value", 256'(mux_in[7:0]), 256'(8'h00));
    chk("byte31_value", 256'(mux_in[255:248]), 256'(8'h1F));
    sweep(8'd5, 8'd9, -1);
    repeat (2) begin
      tick();
      chk("after_sweep_s_ready", 256'(s_ready), 256'(1));
      chk("after_sweep_mux_in", mux_in, exp_vec);
    end

    load_vector(1, 1'b0);
    sweep(8'd250, 8'd3, -1);
    load_vector(1, 1'b0);
    sweep(8'd0, 8'd255, -1);

    load_vector(1, 1'b1);
    sweep(8'd128, 8'd128, -1);

    load_vector(1, 1'b0);
    sweep(8'd0, 8'd255, 3);

    repeat (3) begin
      load_vector(1, 1'b0);
      sweep(8'($urandom), 8'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
